// File: rtl/itch_dec_pkg.sv
// Shared constants and the packed record layout for the ITCH order-lifecycle decoder.
package itch_dec_pkg;

  typedef enum logic [2:0] {
    KIND_NONE   = 3'd0,
    KIND_ADD    = 3'd1,
    KIND_CANCEL = 3'd2,
    KIND_DELETE = 3'd3,
    KIND_EXEC   = 3'd4
  } msg_kind_e;

  localparam logic [7:0] TYPE_ADD    = 8'h41; // 'A'
  localparam logic [7:0] TYPE_CANCEL = 8'h58; // 'X'
  localparam logic [7:0] TYPE_DELETE = 8'h44; // 'D'
  localparam logic [7:0] TYPE_EXEC   = 8'h45; // 'E'
  localparam logic [7:0] SIDE_BUY    = 8'h42; // 'B'

  localparam logic [7:0] LEN_ADD    = 8'd26;
  localparam logic [7:0] LEN_CANCEL = 8'd13;
  localparam logic [7:0] LEN_DELETE = 8'd9;
  localparam logic [7:0] LEN_EXEC   = 8'd21;

  localparam int unsigned OFF_TYPE       = 0;
  localparam int unsigned OFF_REF        = 1;
  localparam int unsigned OFF_ADD_SIDE   = 9;
  localparam int unsigned OFF_ADD_SHARES = 10;
  localparam int unsigned OFF_ADD_STOCK  = 14;
  localparam int unsigned OFF_ADD_PRICE  = 22;
  localparam int unsigned OFF_SHARES     = 9;
  localparam int unsigned OFF_EXEC_MATCH = 13;
  localparam int unsigned MIN_BYTES      = 26;

  typedef struct packed {
    msg_kind_e   kind;
    logic [63:0] order_ref;
    logic        buy_sell;
    logic [31:0] shares;
    logic [31:0] price;
    logic [63:0] stock;
    logic [63:0] match_num;
    logic        len_err;
    logic [8:0]  spare;
  } rec_t;

  localparam int unsigned REC_W = $bits(rec_t);

endpackage

// File: rtl/itch_sync_fifo.sv
// Generic synchronous FIFO; occupancy tracked by a dedicated count register.
module itch_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      mem    <= '{default: '0};
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/itch_order_msg_decoder.sv
// Decodes ITCH Add/Cancel/Delete/Executed messages into a buffered record stream.
// Optional statistics counters are enabled with macro ITCH_DEC_STATS_EN.
module itch_order_msg_decoder
  import itch_dec_pkg::*;
#(
  parameter int unsigned PAYLOAD_W  = 512,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CNT_W      = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PAYLOAD_W-1:0] in_payload,
  input  logic [7:0]           in_len,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2:0]           out_msg_kind,
  output logic [63:0]          out_order_ref,
  output logic                 out_buy_sell,
  output logic [31:0]          out_shares,
  output logic [31:0]          out_price,
  output logic [63:0]          out_stock,
  output logic [63:0]          out_match_num,
  output logic                 out_len_err,
  output logic                 drop_pulse
`ifdef ITCH_DEC_STATS_EN
  ,
  output logic [CNT_W-1:0]     stat_add,
  output logic [CNT_W-1:0]     stat_cancel,
  output logic [CNT_W-1:0]     stat_delete,
  output logic [CNT_W-1:0]     stat_exec,
  output logic [CNT_W-1:0]     stat_len_err,
  output logic [CNT_W-1:0]     stat_drop
`endif
);

  localparam int unsigned TOP = PAYLOAD_W - 1;

  rec_t dec;
  rec_t head;
  rec_t last_rec;
  rec_t shown;
  logic known;
  logic acc;
  logic fifo_full;
  logic fifo_empty;
  logic [REC_W-1:0] fifo_rdata;

  assign acc = in_valid && in_ready;

  always_comb begin
    dec   = '0;
    known = 1'b1;
    case (in_payload[TOP-8*OFF_TYPE -: 8])
      TYPE_ADD: begin
        dec.kind      = KIND_ADD;
        dec.order_ref = in_payload[TOP-8*OFF_REF -: 64];
        dec.buy_sell  = (in_payload[TOP-8*OFF_ADD_SIDE -: 8] == SIDE_BUY);
        dec.shares    = in_payload[TOP-8*OFF_ADD_SHARES -: 32];
        dec.stock     = in_payload[TOP-8*OFF_ADD_STOCK -: 64];
        dec.price     = in_payload[TOP-8*OFF_ADD_PRICE -: 32];
        dec.len_err   = (in_len != LEN_ADD);
      end
      TYPE_CANCEL: begin
        dec.kind      = KIND_CANCEL;
        dec.order_ref = in_payload[TOP-8*OFF_REF -: 64];
        dec.shares    = in_payload[TOP-8*OFF_SHARES -: 32];
        dec.len_err   = (in_len != LEN_CANCEL);
      end
      TYPE_DELETE: begin
        dec.kind      = KIND_DELETE;
        dec.order_ref = in_payload[TOP-8*OFF_REF -: 64];
        dec.len_err   = (in_len != LEN_DELETE);
      end
      TYPE_EXEC: begin
        dec.kind      = KIND_EXEC;
        dec.order_ref = in_payload[TOP-8*OFF_REF -: 64];
        dec.shares    = in_payload[TOP-8*OFF_SHARES -: 32];
        dec.match_num = in_payload[TOP-8*OFF_EXEC_MATCH -: 64];
        dec.len_err   = (in_len != LEN_EXEC);
      end
      default: known = 1'b0;
    endcase
  end

  generate
    if (PAYLOAD_W > 8*MIN_BYTES) begin : g_tail
      logic unused_tail;
      assign unused_tail = ^in_payload[PAYLOAD_W-1-8*MIN_BYTES:0];
    end
  endgenerate

  itch_sync_fifo #(
    .WIDTH(REC_W),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .push (acc && known),
    .wdata(dec),
    .pop  (out_ready),
    .rdata(fifo_rdata),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  assign head      = rec_t'(fifo_rdata);
  assign in_ready  = !fifo_full;
  assign out_valid = !fifo_empty;

  // Once drained, the FIFO slot under rd_ptr may be older than the last head, so keep a copy.
  assign shown = fifo_empty ? last_rec : head;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_rec   <= '0;
      drop_pulse <= 1'b0;
    end else begin
      if (!fifo_empty) last_rec <= head;
      drop_pulse <= acc && !known;
    end
  end

  assign out_msg_kind  = shown.kind;
  assign out_order_ref = shown.order_ref;
  assign out_buy_sell  = shown.buy_sell;
  assign out_shares    = shown.shares;
  assign out_price     = shown.price;
  assign out_stock     = shown.stock;
  assign out_match_num = shown.match_num;
  assign out_len_err   = shown.len_err;

`ifdef ITCH_DEC_STATS_EN
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic en);
    return (en && (c != '1)) ? c + CNT_W'(1) : c;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_add     <= '0;
      stat_cancel  <= '0;
      stat_delete  <= '0;
      stat_exec    <= '0;
      stat_len_err <= '0;
      stat_drop    <= '0;
    end else begin
      stat_add     <= sat_inc(stat_add,     acc && known && dec.kind == KIND_ADD);
      stat_cancel  <= sat_inc(stat_cancel,  acc && known && dec.kind == KIND_CANCEL);
      stat_delete  <= sat_inc(stat_delete,  acc && known && dec.kind == KIND_DELETE);
      stat_exec    <= sat_inc(stat_exec,    acc && known && dec.kind == KIND_EXEC);
      stat_len_err <= sat_inc(stat_len_err, acc && known && dec.len_err);
      stat_drop    <= sat_inc(stat_drop,    acc && !known);
    end
  end
`endif

endmodule

// File: tb/tb_itch_order_msg_decoder.sv
// Directed, table-driven bench for itch_order_msg_decoder (stats checks under ITCH_DEC_STATS_EN).
module tb_itch_order_msg_decoder;

  localparam int unsigned PW = 512;
  localparam logic [63:0] STK_AAPL = 64'h4141504C20202020;
  localparam logic [63:0] STK_MSFT = 64'h4D53465420202020;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [PW-1:0] in_payload;
  logic [7:0]    in_len;
  logic          out_valid;
  logic          out_ready;
  logic [2:0]    out_msg_kind;
  logic [63:0]   out_order_ref;
  logic          out_buy_sell;
  logic [31:0]   out_shares;
  logic [31:0]   out_price;
  logic [63:0]   out_stock;
  logic [63:0]   out_match_num;
  logic          out_len_err;
  logic          drop_pulse;
`ifdef ITCH_DEC_STATS_EN
  logic [31:0] stat_add, stat_cancel, stat_delete, stat_exec, stat_len_err, stat_drop;
  logic        s_in_ready, s_out_valid, s_buy_sell, s_len_err, s_drop;
  logic [2:0]  s_kind;
  logic [63:0] s_ref, s_stock, s_match;
  logic [31:0] s_shares, s_price;
  logic [1:0]  s_add, s_cancel, s_delete, s_exec, s_lerr, s_sdrop;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  itch_order_msg_decoder #(
    .PAYLOAD_W (PW),
    .FIFO_DEPTH(4),
    .CNT_W     (32)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_payload   (in_payload),
    .in_len       (in_len),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_msg_kind (out_msg_kind),
    .out_order_ref(out_order_ref),
    .out_buy_sell (out_buy_sell),
    .out_shares   (out_shares),
    .out_price    (out_price),
    .out_stock    (out_stock),
    .out_match_num(out_match_num),
    .out_len_err  (out_len_err),
    .drop_pulse   (drop_pulse)
`ifdef ITCH_DEC_STATS_EN
    ,
    .stat_add     (stat_add),
    .stat_cancel  (stat_cancel),
    .stat_delete  (stat_delete),
    .stat_exec    (stat_exec),
    .stat_len_err (stat_len_err),
    .stat_drop    (stat_drop)
`endif
  );

`ifdef ITCH_DEC_STATS_EN
  itch_order_msg_decoder #(
    .PAYLOAD_W (PW),
    .FIFO_DEPTH(4),
    .CNT_W     (2)
  ) dut_sat (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (s_in_ready),
    .in_payload   (in_payload),
    .in_len       (in_len),
    .out_valid    (s_out_valid),
    .out_ready    (out_ready),
    .out_msg_kind (s_kind),
    .out_order_ref(s_ref),
    .out_buy_sell (s_buy_sell),
    .out_shares   (s_shares),
    .out_price    (s_price),
    .out_stock    (s_stock),
    .out_match_num(s_match),
    .out_len_err  (s_len_err),
    .drop_pulse   (s_drop),
    .stat_add     (s_add),
    .stat_cancel  (s_cancel),
    .stat_delete  (s_delete),
    .stat_exec    (s_exec),
    .stat_len_err (s_lerr),
    .stat_drop    (s_sdrop)
  );
`endif

  typedef struct {
    logic [63:0] typ, oref, side, shares, stock, price, match_num, len;
    logic [63:0] e_kind, e_bs, e_shares, e_price, e_stock, e_match, e_lerr, e_drop;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [PW-1:0] put(input logic [PW-1:0] p, input int off, input int n,
                                        input logic [63:0] val);
    logic [PW-1:0] r;
    r = p;
    for (int k = 0; k < n; k++) r[PW-1-8*(off+k) -: 8] = val[8*(n-1-k) +: 8];
    return r;
  endfunction

  function automatic logic [PW-1:0] make_payload(input vec_t v);
    logic [PW-1:0] p;
    p = {(PW/8){8'hA5}};
    p = put(p, 0, 1, v.typ);
    case (v.typ[7:0])
      8'h41: begin
        p = put(p, 1, 8, v.oref);   p = put(p, 9, 1, v.side);   p = put(p, 10, 4, v.shares);
        p = put(p, 14, 8, v.stock); p = put(p, 22, 4, v.price);
      end
      8'h58: begin p = put(p, 1, 8, v.oref); p = put(p, 9, 4, v.shares); end
      8'h44: p = put(p, 1, 8, v.oref);
      8'h45: begin
        p = put(p, 1, 8, v.oref); p = put(p, 9, 4, v.shares); p = put(p, 13, 8, v.match_num);
      end
      default: ;
    endcase
    return p;
  endfunction

  function automatic logic [PW-1:0] mk_add(input logic [63:0] sh);
    vec_t v;
    v = '{64'h41, 64'h100 + sh, 64'h42, sh, STK_AAPL, 64'd10, 64'd0, 64'd26,
          64'd0, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0};
    return make_payload(v);
  endfunction

  // Entered and left at a falling edge: present one beat for one rising edge.
  task automatic send(input logic [PW-1:0] p, input logic [7:0] len);
    in_payload = p;
    in_len     = len;
    in_valid   = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    //         typ     ref                     side    shares   stock     price       match      len
    //         kind    bs      shares   price        stock     match      lerr    drop
    vecs[0] = '{64'h41, 64'h1234,              64'h42, 64'd100, STK_AAPL, 64'hF4240,  64'h0,     64'd26,
                64'd1,  64'd1,  64'd100, 64'hF4240,  STK_AAPL, 64'h0,     64'd0,  64'd0};
    vecs[1] = '{64'h58, 64'd5,                 64'h0,  64'd40,  64'h0,    64'h0,      64'h0,     64'd13,
                64'd2,  64'd0,  64'd40,  64'h0,      64'h0,    64'h0,     64'd0,  64'd0};
    vecs[2] = '{64'h44, 64'd5,                 64'h0,  64'd0,   64'h0,    64'h0,      64'h0,     64'd9,
                64'd3,  64'd0,  64'd0,   64'h0,      64'h0,    64'h0,     64'd0,  64'd0};
    vecs[3] = '{64'h45, 64'd7,                 64'h0,  64'd10,  64'h0,    64'h0,      64'hABCD,  64'd21,
                64'd4,  64'd0,  64'd10,  64'h0,      64'h0,    64'hABCD,  64'd0,  64'd0};
    vecs[4] = '{64'h51, 64'd0,                 64'h0,  64'd0,   64'h0,    64'h0,      64'h0,     64'd26,
                64'd0,  64'd0,  64'd0,   64'h0,      64'h0,    64'h0,     64'd0,  64'd1};
    vecs[5] = '{64'h41, 64'hDEADBEEF00000001,  64'h53, 64'd7,   STK_MSFT, 64'd5,      64'h0,     64'd30,
                64'd1,  64'd0,  64'd7,   64'd5,      STK_MSFT, 64'h0,     64'd1,  64'd0};
    vecs[6] = '{64'h44, 64'd9,                 64'h0,  64'd0,   64'h0,    64'h0,      64'h0,     64'd8,
                64'd3,  64'd0,  64'd0,   64'h0,      64'h0,    64'h0,     64'd1,  64'd0};
    vecs[7] = '{64'h58, 64'hFFFFFFFFFFFFFFFF,  64'h0,  64'hFFFFFFFF, 64'h0, 64'h0,     64'h0,     64'd12,
                64'd2,  64'd0,  64'hFFFFFFFF, 64'h0, 64'h0,    64'h0,     64'd1,  64'd0};

    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_payload = '0;
    in_len     = '0;
    out_ready  = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_drop", 64'(drop_pulse), 64'd0);
    chk("rst_kind", 64'(out_msg_kind), 64'd0);

    for (int i = 0; i < 8; i++) begin
      send(make_payload(vecs[i]), vecs[i].len[7:0]);
      chk($sformatf("v%0d_in_ready", i), 64'(in_ready), 64'd1);
      chk($sformatf("v%0d_drop", i), 64'(drop_pulse), vecs[i].e_drop);
      if (vecs[i].e_drop != 0) begin
        chk($sformatf("v%0d_out_valid", i), 64'(out_valid), 64'd0);
      end else begin
        chk($sformatf("v%0d_out_valid", i), 64'(out_valid), 64'd1);
        chk($sformatf("v%0d_kind", i), 64'(out_msg_kind), vecs[i].e_kind);
        chk($sformatf("v%0d_ref", i), out_order_ref, vecs[i].oref);
        chk($sformatf("v%0d_bs", i), 64'(out_buy_sell), vecs[i].e_bs);
        chk($sformatf("v%0d_shares", i), 64'(out_shares), vecs[i].e_shares);
        chk($sformatf("v%0d_price", i), 64'(out_price), vecs[i].e_price);
        chk($sformatf("v%0d_stock", i), out_stock, vecs[i].e_stock);
        chk($sformatf("v%0d_match", i), out_match_num, vecs[i].e_match);
        chk($sformatf("v%0d_len_err", i), 64'(out_len_err), vecs[i].e_lerr);
      end
    end

    // Unknown type: single-cycle drop pulse, nothing emitted.
    send(make_payload(vecs[4]), 8'd26);
    chk("q_drop", 64'(drop_pulse), 64'd1);
    chk("q_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    chk("q_drop_clear", 64'(drop_pulse), 64'd0);
    chk("q_valid_idle", 64'(out_valid), 64'd0);

    // Back-pressure: fill, hold, pop one, accept the fifth, drain in order.
    out_ready = 1'b0;
    in_len    = 8'd26;
    for (int i = 1; i <= 4; i++) begin
      chk($sformatf("bp_rdy%0d", i), 64'(in_ready), 64'd1);
      in_payload = mk_add(64'(i));
      in_valid   = 1'b1;
      @(negedge clk);
    end
    chk("bp_full_rdy", 64'(in_ready), 64'd0);
    in_payload = mk_add(64'd5);
    @(negedge clk);
    chk("bp_hold_rdy", 64'(in_ready), 64'd0);
    chk("bp_hold_valid", 64'(out_valid), 64'd1);
    chk("bp_hold_shares", 64'(out_shares), 64'd1);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    chk("bp_after_pop_rdy", 64'(in_ready), 64'd1);
    chk("bp_after_pop_shares", 64'(out_shares), 64'd2);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    chk("bp_refull_rdy", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    for (int s = 2; s <= 5; s++) begin
      chk($sformatf("drain%0d_valid", s), 64'(out_valid), 64'd1);
      chk($sformatf("drain%0d_shares", s), 64'(out_shares), 64'(s));
      @(negedge clk);
    end
    chk("drain_empty_valid", 64'(out_valid), 64'd0);
    chk("drain_empty_hold", 64'(out_shares), 64'd5);

    // Reset with three records buffered.
    out_ready = 1'b0;
    for (int i = 1; i <= 3; i++) send(mk_add(64'(i + 20)), 8'd26);
    chk("pre_rst_valid", 64'(out_valid), 64'd1);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_rdy", 64'(in_ready), 64'd1);
    chk("mid_rst_ref", out_order_ref, 64'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("no_stale%0d", i), 64'(out_valid), 64'd0);
    end

`ifdef ITCH_DEC_STATS_EN
    send(mk_add(64'd1), 8'd26);
    send(mk_add(64'd2), 8'd26);
    send(make_payload(vecs[4]), 8'd26);
    send(make_payload(vecs[1]), 8'd14);
    chk("stat_add", 64'(stat_add), 64'd2);
    chk("stat_drop", 64'(stat_drop), 64'd1);
    chk("stat_cancel", 64'(stat_cancel), 64'd1);
    chk("stat_len_err", 64'(stat_len_err), 64'd1);
    chk("stat_delete", 64'(stat_delete), 64'd0);
    chk("stat_exec", 64'(stat_exec), 64'd0);
    send(mk_add(64'd3), 8'd26);
    send(mk_add(64'd4), 8'd26);
    chk("stat_add4", 64'(stat_add), 64'd4);
    chk("stat_add_sat", 64'(s_add), 64'd3);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/itch_order_msg_decoder.md
Name: itch_order_msg_decoder

Overview:
Parametrised successor to the single-type Add Order decoder. Decodes four order-lifecycle ITCH message types from a byte-aligned payload bus: Add 'A', Cancel 'X', Delete 'D', Executed 'E'. Checks each declared length against the expected length for its type. Decoded records are buffered in an output FIFO with valid/ready back-pressure. Sits between the payload dispatcher and the order-book update logic.

Parameters:
PAYLOAD_W  512  payload bus width in bits; multiple of 8, at least 208
FIFO_DEPTH  4  output FIFO entries; power of 2, at least 2
CNT_W  32  width of the statistics counters (optional feature only)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
in_valid  in  1  payload beat valid
in_ready  out  1  block can accept a beat
in_payload  in  PAYLOAD_W  message; byte k at [PAYLOAD_W-1-8k -: 8], byte 0 = type
in_len  in  8  declared message length in bytes
out_valid  out  1  FIFO head holds a record
out_ready  in  1  consumer accepts the head
out_msg_kind  out  3  1=ADD 2=CANCEL 3=DELETE 4=EXEC
out_order_ref  out  64  order reference number
out_buy_sell  out  1  1=Buy ('B'), 0 otherwise; ADD only, else 0
out_shares  out  32  ADD shares, CANCEL cancelled shares, EXEC executed shares; 0 for DELETE
out_price  out  32  ADD only, else 0
out_stock  out  64  ADD only, else 0
out_match_num  out  64  EXEC only, else 0
out_len_err  out  1  in_len differed from the expected length
drop_pulse  out  1  one-cycle pulse when an accepted beat has an unknown type

Behaviour:
- Reset behaviour: synchronous; when rst_n=0 at a clk edge, FIFO pointers and count clear, all storage clears to 0, out_valid=0, drop_pulse=0.
- Reset mid-operation: buffered records are discarded. in_ready=1 in the first cycle after reset deasserts.
- Accept: a beat is accepted when in_valid && in_ready.
- in_ready = !full. in_ready is registered-state only; there is no combinational path from out_ready.
- Decode is combinational on the accepted beat. The record is written to the FIFO at that edge.
- Latency: out_valid rises 1 cycle after acceptance when the FIFO was empty.
- Field layout, by byte index:
  - ADD: ref 1-8, side 9, shares 10-13, stock 14-21, price 22-25; expected length 26.
  - CANCEL: ref 1-8, shares 9-12; expected length 13.
  - DELETE: ref 1-8; expected length 9.
  - EXEC: ref 1-8, shares 9-12, match 13-20; expected length 21.
- Unused fields for a type are written as 0.
- Length mismatch on a known type: the record is still pushed with out_len_err=1, and its fields are decoded from the bytes present.
- Unknown type byte: nothing is pushed; drop_pulse=1 in the next cycle. The beat is still consumed (in_ready rules unchanged).
- Pop: occurs when out_valid && out_ready. The outputs show the next entry the following cycle.
- Simultaneous push and pop when not full: count unchanged and pointers both advance.
- Full state: no push. in_ready stays 0 even if out_ready=1 in the same cycle; it rises one cycle after the pop.
- Empty state: out_valid=0 and the output fields hold the last head value. Consumers must ignore them.
- Pointer wrap: pointers wrap modulo FIFO_DEPTH. Full/empty is derived from a separate count register of width log2(FIFO_DEPTH)+1.
- Output stability: while out_valid=1 && out_ready=0, the outputs are held stable.

Optional Feature:
Macro ITCH_DEC_STATS_EN.
- Defined: adds outputs stat_add, stat_cancel, stat_delete, stat_exec, stat_len_err and stat_drop, each CNT_W wide.
  - Each counter increments by 1 at the edge that accepts a beat of that category (len_err counts in addition to its type).
  - Counters saturate at all-ones and clear on reset.
- Undefined: these ports and registers do not exist. All other behaviour is identical.

Decomposition:
- Package itch_dec_pkg holds:
  - msg-kind codes (KIND_ADD=1, KIND_CANCEL=2, KIND_DELETE=3, KIND_EXEC=4);
  - ASCII type constants 'A', 'X', 'D', 'E', 'B';
  - expected lengths 26/13/9/21;
  - byte-offset constants;
  - the packed record width (270 bits: kind 3 + ref 64 + side 1 + shares 32 + price 32 + stock 64 + match 64 + len_err 1 + spare 9 reserved as 0).
- Sub-module itch_sync_fifo (WIDTH, DEPTH): generic synchronous FIFO with count, full and empty. The decoder packs and unpacks records around it.

Test Plan:
- ADD: type 'A', ref 0x0000_0000_0000_1234, side 'B', shares 100, stock "AAPL    ", price 0x000F4240, len 26 -> next cycle out_valid=1, kind=1, buy_sell=1, shares=100, price=0x000F4240, len_err=0.
- Mixed stream X(ref 5, shares 40, len 13), D(ref 5, len 9), E(ref 7, shares 10, match 0xABCD, len 21) with out_ready=1 -> three records in order with kinds 2,3,4; DELETE shares=0; EXEC match=0xABCD.
- Back-pressure: out_ready=0, push 5 ADDs with FIFO_DEPTH=4 -> in_ready=0 after the 4th. Pop one -> in_ready=1 the next cycle and the 5th is accepted. All 5 drain in order.
- Error cases: type 'Q' -> drop_pulse=1 for one cycle and out_valid stays 0. ADD with len 30 -> record with len_err=1.
- Reset mid-operation: 3 entries buffered, rst_n=0 for one edge -> out_valid=0, in_ready=1 after release, no stale records emitted.
- With ITCH_DEC_STATS_EN: 2 ADD, 1 'Q', 1 bad-length X -> stat_add=2, stat_drop=1, stat_cancel=1, stat_len_err=1. Preload stat_add near saturation with CNT_W=2 -> it stays at 3.
